// File: rtl/enigma_core_param.sv
// Parametrised rotor cipher core: NUM_ROTORS rotors plus a reflector over an
// ALPHA-symbol alphabet. One symbol is processed at a time. A single FSM walks
// the rotors forward, through the reflector and back. Wiring, inverse wiring,
// position and notch tables are all runtime-loadable while the core is idle.
module enigma_core_param #(
    parameter int NUM_ROTORS = 3,
    parameter int ALPHA      = 26,
    parameter int SYM_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] dout,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_kind,
    input  logic [3:0]       cfg_tbl,
    input  logic [SYM_W-1:0] cfg_addr,
    input  logic [SYM_W-1:0] cfg_data,
    output logic             cfg_ready
);
    localparam int AW = (ALPHA > 1) ? $clog2(ALPHA) : 1;
    localparam int RW = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;

    typedef enum logic [2:0] {IDLE, FWD, REFL, BWD, OUT} state_t;

    state_t           state;
    logic [SYM_W-1:0] x;
    logic [RW-1:0]    r;
    logic             bypass;

    logic [SYM_W-1:0] w     [NUM_ROTORS][ALPHA];
    logic [SYM_W-1:0] winv  [NUM_ROTORS][ALPHA];
    logic [SYM_W-1:0] refl  [ALPHA];
    logic [SYM_W-1:0] pos   [NUM_ROTORS];
    logic [SYM_W-1:0] notch [NUM_ROTORS];

    logic [SYM_W:0]   sum, diff;
    logic [SYM_W-1:0] px, tv, nx;
    logic [AW-1:0]    idx;
    logic [NUM_ROTORS-1:0] step;
    logic             step_en, cfg_ok;
    logic             unused_bits;

    // Rotor datapath for the current rotor r: offset by position, look up, un-offset
    always_comb begin
        px  = pos[r];
        sum = {1'b0, x} + {1'b0, px};
        if (sum >= (SYM_W+1)'(ALPHA))
            sum = sum - (SYM_W+1)'(ALPHA);
        idx = sum[AW-1:0];
        tv  = (state == BWD) ? winv[r][idx] : w[r][idx];
        diff = {1'b0, tv} - {1'b0, px};
        if (tv < px)
            diff = diff + (SYM_W+1)'(ALPHA);
        nx = diff[SYM_W-1:0];
    end

    assign unused_bits = ^{sum[SYM_W:AW], diff[SYM_W]};

    // Odometer carry chain, evaluated on pre-step positions
    always_comb begin
        step    = '0;
        step[0] = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++)
            step[i] = step[i-1] && (pos[i-1] == notch[i-1]);
    end

    // Stepping happens on the edge leaving the last backward rotor (entering OUT)
    assign step_en = (state == BWD) && (r == '0);

    assign cfg_ok = cfg_we && (state == IDLE)
                 && (cfg_addr < SYM_W'(ALPHA)) && (cfg_data < SYM_W'(ALPHA))
                 && (cfg_tbl <= 4'(NUM_ROTORS)) && (cfg_kind != 2'd3)
                 && !((cfg_tbl == 4'(NUM_ROTORS)) && (cfg_kind != 2'd0));

    // Table storage: reset defaults, config writes in IDLE, odometer stepping
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                pos[i]   <= '0;
                notch[i] <= SYM_W'(ALPHA - 1);
                for (int a = 0; a < ALPHA; a++) begin
                    w[i][a]    <= SYM_W'(a);
                    winv[i][a] <= SYM_W'(a);
                end
            end
            for (int a = 0; a < ALPHA; a++)
                refl[a] <= ((ALPHA % 2 == 1) && (a == ALPHA - 1)) ? SYM_W'(a) : SYM_W'(a ^ 1);
        end else begin
            if (cfg_ok) begin
                case (cfg_kind)
                    2'd0: begin
                        if (cfg_tbl == 4'(NUM_ROTORS)) begin
                            refl[cfg_addr[AW-1:0]] <= cfg_data;
                        end else begin
                            w[cfg_tbl[RW-1:0]][cfg_addr[AW-1:0]]    <= cfg_data;
                            winv[cfg_tbl[RW-1:0]][cfg_data[AW-1:0]] <= cfg_addr;
                        end
                    end
                    2'd1:    pos[cfg_tbl[RW-1:0]]   <= cfg_data;
                    2'd2:    notch[cfg_tbl[RW-1:0]] <= cfg_data;
                    default: ;
                endcase
            end
            if (step_en) begin
                for (int i = 0; i < NUM_ROTORS; i++)
                    if (step[i])
                        pos[i] <= (pos[i] == SYM_W'(ALPHA - 1)) ? '0 : pos[i] + SYM_W'(1);
            end
        end
    end

    // Sequencing FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            r         <= '0;
            bypass    <= 1'b0;
            in_ready  <= 1'b1;
            cfg_ready <= 1'b1;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x         <= din;
                        r         <= '0;
                        bypass    <= (din >= SYM_W'(ALPHA));
                        in_ready  <= 1'b0;
                        cfg_ready <= 1'b0;
                        state     <= FWD;
                    end
                end
                FWD: begin
                    if (bypass) begin
                        state <= OUT;
                    end else begin
                        x <= nx;
                        if (r == RW'(NUM_ROTORS - 1))
                            state <= REFL;
                        else
                            r <= r + RW'(1);
                    end
                end
                REFL: begin
                    x     <= refl[x[AW-1:0]];
                    r     <= RW'(NUM_ROTORS - 1);
                    state <= BWD;
                end
                BWD: begin
                    x <= nx;
                    if (r == '0)
                        state <= OUT;
                    else
                        r <= r - RW'(1);
                end
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        dout      <= x;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enigma_core_param.sv
// Directed bench for enigma_core_param at default parameters (N=3, ALPHA=26).
module tb_enigma_core_param;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] din = '0;
    logic       out_valid, out_ready = 1'b0;
    logic [7:0] dout;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_kind = '0;
    logic [3:0] cfg_tbl = '0;
    logic [7:0] cfg_addr = '0, cfg_data = '0;
    logic       cfg_ready;

    int n_chk = 0;
    int n_fail = 0;

    // reference tables
    int m_w [3][26];
    int m_wi[3][26];
    int m_pos[3];
    int m_notch[3];

    enigma_core_param dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_tbl(cfg_tbl),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 3; r++) begin
            m_pos[r] = 0;
            m_notch[r] = 25;
            for (int a = 0; a < 26; a++) begin
                m_w[r][a] = a;
                m_wi[r][a] = a;
            end
        end
    endtask

    task automatic model_enc(input int xi, output int y);
        int x;
        bit st[3];
        x = xi;
        for (int r = 0; r < 3; r++)
            x = (m_w[r][(x + m_pos[r]) % 26] - m_pos[r] + 26) % 26;
        x = x ^ 1;
        for (int r = 2; r >= 0; r--)
            x = (m_wi[r][(x + m_pos[r]) % 26] - m_pos[r] + 26) % 26;
        y = x;
        st[0] = 1'b1;
        st[1] = st[0] && (m_pos[0] == m_notch[0]);
        st[2] = st[1] && (m_pos[1] == m_notch[1]);
        for (int r = 0; r < 3; r++)
            if (st[r]) m_pos[r] = (m_pos[r] + 1) % 26;
    endtask

    task automatic cfg_write(input int k, input int t, input int a, input int d);
        cfg_we = 1'b1;
        cfg_kind = 2'(k);
        cfg_tbl = 4'(t);
        cfg_addr = 8'(a);
        cfg_data = 8'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    // one full transaction; lat = cycles from accept edge to out_valid, -1 on timeout
    task automatic send(input int sym, output int res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        din = 8'(sym);
        tick();
        in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 60);
        if (!out_valid) lat = -1;
        res = int'(dout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_pos(input string tag);
        chk({tag, " p0"}, int'(dut.pos[0]), m_pos[0]);
        chk({tag, " p1"}, int'(dut.pos[1]), m_pos[1]);
        chk({tag, " p2"}, int'(dut.pos[2]), m_pos[2]);
    endtask

    initial begin
        int res, lat, y, d0;
        int hello[5];
        int ct[5];
        int mul[3];
        int add[3];
        hello = '{7, 4, 11, 11, 14};
        mul = '{3, 5, 7};
        add = '{1, 4, 9};
        model_reset();

        // reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst cfg_ready", int'(cfg_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst dout", int'(dout), 0);
        chk_pos("rst");

        // 1: defaults, din=0 -> 1 after 8 cycles, p0 steps
        send(0, res, lat);
        model_enc(0, y);
        chk("t1 dout", res, 1);
        chk("t1 latency", lat, 8);
        chk_pos("t1");

        // 2: odometer double carry
        cfg_write(1, 0, 0, 25); m_pos[0] = 25;
        cfg_write(1, 1, 0, 25); m_pos[1] = 25;
        cfg_write(2, 1, 0, 25); m_notch[1] = 25;
        send(0, res, lat);
        model_enc(0, y);
        chk("t2a dout", res, y);
        chk("t2a p0", int'(dut.pos[0]), 0);
        chk("t2a p1", int'(dut.pos[1]), 0);
        chk("t2a p2", int'(dut.pos[2]), 1);
        send(0, res, lat);
        model_enc(0, y);
        chk("t2b p0", int'(dut.pos[0]), 1);
        chk("t2b p1", int'(dut.pos[1]), 0);
        chk("t2b p2", int'(dut.pos[2]), 1);

        // illegal config writes must be dropped
        cfg_write(1, 0, 0, 30);
        cfg_write(1, 3, 0, 5);
        cfg_write(3, 0, 0, 5);
        cfg_write(0, 4, 0, 5);
        chk_pos("drop");

        // 3: non-identity rotors, HELLO round trip
        for (int r = 0; r < 3; r++)
            for (int a = 0; a < 26; a++) begin
                cfg_write(0, r, a, (a * mul[r] + add[r]) % 26);
                m_w[r][a] = (a * mul[r] + add[r]) % 26;
                m_wi[r][(a * mul[r] + add[r]) % 26] = a;
            end
        cfg_write(1, 0, 0, 3);  m_pos[0] = 3;
        cfg_write(1, 1, 0, 7);  m_pos[1] = 7;
        cfg_write(1, 2, 0, 11); m_pos[2] = 11;
        for (int i = 0; i < 5; i++) begin
            send(hello[i], res, lat);
            model_enc(hello[i], y);
            ct[i] = res;
            chk("t3 enc", res, y);
            chk("t3 no fixed point", int'(res != hello[i]), 1);
        end
        cfg_write(1, 0, 0, 3);  m_pos[0] = 3;
        cfg_write(1, 1, 0, 7);  m_pos[1] = 7;
        cfg_write(1, 2, 0, 11); m_pos[2] = 11;
        for (int i = 0; i < 5; i++) begin
            send(ct[i], res, lat);
            model_enc(ct[i], y);
            chk("t3 dec", res, hello[i]);
        end
        chk_pos("t3");

        // 4: out-of-alphabet pass-through
        send(30, res, lat);
        chk("t4 dout", res, 30);
        chk("t4 latency", lat, 2);
        chk_pos("t4");

        // 5: backpressure with a config write attempted while busy
        in_valid = 1'b1;
        din = 8'd9;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk("t5 out_valid seen", int'(out_valid), 1);
        model_enc(9, y);
        d0 = int'(dout);
        chk("t5 dout", d0, y);
        cfg_we = 1'b1; cfg_kind = 2'd1; cfg_tbl = 4'd0; cfg_addr = 8'd0; cfg_data = 8'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5 hold valid", int'(out_valid), 1);
            chk("t5 hold dout", int'(dout), d0);
            chk("t5 in_ready low", int'(in_ready), 0);
            chk("t5 cfg_ready low", int'(cfg_ready), 0);
        end
        cfg_we = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5 in_ready back", int'(in_ready), 1);
        chk("t5 out_valid drop", int'(out_valid), 0);
        chk_pos("t5");

        // 6: reset during BWD aborts and restores defaults
        in_valid = 1'b1;
        din = 8'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk("t6 out_valid", int'(out_valid), 0);
        chk("t6 in_ready", int'(in_ready), 1);
        chk("t6 w", int'(dut.w[0][4]), 4);
        chk("t6 winv", int'(dut.winv[1][7]), 7);
        chk_pos("t6");
        for (int i = 0; i < 10; i++) tick();
        chk("t6 no late output", int'(out_valid), 0);
        send(0, res, lat);
        model_enc(0, y);
        chk("t6 dout", res, 1);
        chk("t6 latency", lat, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
